// File: rtl/seg_scan_ctrl_if.sv
// Interface bundle for the 7-segment scan controller: host-side controls in,
// display drive out. The host side uses the master view, the controller the slave view.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIG = 4
);
    logic                   en;
    logic                   load;
    logic [4*NUM_DIG-1:0]   data_in;
    logic [NUM_DIG-1:0]     dp_in;
    logic                   lz_en;
    logic [3:0]             bcd;
    logic [NUM_DIG-1:0]     dig_an;
    logic                   dp_n;
    logic                   pending;
    logic                   frame_tick;

    modport master (
        output en, load, data_in, dp_in, lz_en,
        input  bcd, dig_an, dp_n, pending, frame_tick
    );

    modport slave (
        input  en, load, data_in, dp_in, lz_en,
        output bcd, dig_an, dp_n, pending, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. One shared BCD decoder is fed the current digit; each digit slot is
// a blanking gap followed by a lit period. The display value is double-buffered
// and only committed at a frame boundary (or while dark) to avoid tearing.
//
// state | meaning
// BLANK | all anodes off, bcd already presents digit idx
// SHOW  | anode idx on (unless leading-zero suppressed), dp driven
//
// Outputs are registered from the current state, so they trail the state
// register by one clock. en=0 and rst act on the outputs in the same edge.
module seg_scan_ctrl #(
    parameter int NUM_DIG   = 4,
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_ctrl_if.slave  bus
);

    localparam int IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIG - 1);
    localparam logic [NUM_DIG-1:0] AN_OFF   = {NUM_DIG{1'b1}};

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [CNT_W-1:0]       cnt;
    logic                   wrap_flag;

    logic [4*NUM_DIG-1:0]   act;
    logic [NUM_DIG-1:0]     act_dp;
    logic [4*NUM_DIG-1:0]   shd;
    logic [NUM_DIG-1:0]     shd_dp;
    logic                   pend;

    logic [3:0]             bcd_q;
    logic [NUM_DIG-1:0]     dig_an_q;
    logic                   dp_n_q;
    logic                   pending_q;
    logic                   tick_q;

    logic [NUM_DIG-1:0]     supp;
    logic                   upper_zero;
    logic [3:0]             cur_nib;
    logic                   cur_dp;
    logic                   cur_supp;
    logic [NUM_DIG-1:0]     an_sel;
    logic                   wrap_now;
    logic                   commit;

    // Leading-zero mask: a digit goes dark when it and everything above it is
    // zero, except digit 0 and any digit carrying a decimal point.
    always_comb begin
        upper_zero = 1'b1;
        supp       = '0;
        for (int k = NUM_DIG - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (act[4*k +: 4] == 4'd0);
            supp[k]    = bus.lz_en && upper_zero && (k != 0) && !act_dp[k];
        end
    end

    // Select the nibble, decimal point and suppression bit of the current digit.
    always_comb begin
        cur_nib  = 4'd0;
        cur_dp   = 1'b0;
        cur_supp = 1'b0;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib  = act[4*k +: 4];
                cur_dp   = act_dp[k];
                cur_supp = supp[k];
            end
        end
    end

    // Frame wrap and commit qualification for the current state.
    always_comb begin
        an_sel   = ~(NUM_DIG'(1) << idx);
        wrap_now = (state == SHOW) && (cnt == SHOW_LAST) && (idx == IDX_LAST);
        // Committing while dark is safe: nothing is on the display to tear.
        commit   = pend && (!bus.en || wrap_now);
    end

    // Scan FSM, double buffer and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BLANK;
            idx       <= '0;
            cnt       <= '0;
            wrap_flag <= 1'b0;
            act       <= '0;
            act_dp    <= '0;
            shd       <= '0;
            shd_dp    <= '0;
            pend      <= 1'b0;
            bcd_q     <= 4'd0;
            dig_an_q  <= AN_OFF;
            dp_n_q    <= 1'b1;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            bcd_q     <= cur_nib;
            pending_q <= pend;

            if (!bus.en) begin
                dig_an_q <= AN_OFF;
                dp_n_q   <= 1'b1;
                tick_q   <= 1'b0;
            end else begin
                tick_q <= wrap_flag;
                if (state == SHOW && !cur_supp) begin
                    dig_an_q <= an_sel;
                    dp_n_q   <= ~cur_dp;
                end else begin
                    dig_an_q <= AN_OFF;
                    dp_n_q   <= 1'b1;
                end
            end

            wrap_flag <= 1'b0;
            if (!bus.en) begin
                state <= BLANK;
                idx   <= '0;
                cnt   <= '0;
            end else begin
                case (state)
                    BLANK: begin
                        if (cnt == BLANK_LAST) begin
                            state <= SHOW;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    SHOW: begin
                        if (cnt == SHOW_LAST) begin
                            state <= BLANK;
                            cnt   <= '0;
                            if (idx == IDX_LAST) begin
                                idx       <= '0;
                                wrap_flag <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= BLANK;
                        cnt   <= '0;
                    end
                endcase
            end

            // Commit sees the shadow from before any same-cycle load.
            if (commit) begin
                act    <= shd;
                act_dp <= shd_dp;
            end
            if (bus.load) begin
                shd    <= bus.data_in;
                shd_dp <= bus.dp_in;
                pend   <= 1'b1;
            end else if (commit) begin
                pend <= 1'b0;
            end
        end
    end

    assign bus.bcd        = bcd_q;
    assign bus.dig_an     = dig_an_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.pending    = pending_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a frame-position reference model.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int CD = 8;
    localparam int BC = 2;
    localparam int DP = BC + CD;
    localparam int FR = ND * DP;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.NUM_DIG(ND)) bus ();

    seg_scan_ctrl #(
        .NUM_DIG   (ND),
        .CLK_DIV   (CD),
        .BLANK_CYC (BC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: scan position since (re)start, active/shadow values.
    int          q;
    logic [15:0] m_act, m_shd;
    logic [3:0]  m_adp, m_sdp;
    bit          m_pend;

    logic [3:0]  e_bcd, e_an;
    logic        e_dpn, e_pend, e_tick;

    bit cur_en;
    bit cur_lz;
    int n_cmp = 0;
    int n_bad = 0;

    function automatic int msd(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = 0; i < ND; i++)
            if (v[4*i +: 4] != 4'd0) r = i;
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s at t=%0t q=%0d: observed %0h expected %0h", tag, $time, q, got, exp);
        end
    endtask

    task automatic tick(input bit r, input bit ld, input logic [15:0] d, input logic [3:0] dp);
        int  dg, w;
        bit  lit, show, boundary;
        rst          = r;
        bus.en       = cur_en;
        bus.lz_en    = cur_lz;
        bus.load     = ld;
        bus.data_in  = d;
        bus.dp_in    = dp;
        @(posedge clk);
        if (r) begin
            e_bcd = 4'd0; e_an = 4'hF; e_dpn = 1'b1; e_pend = 1'b0; e_tick = 1'b0;
            q = 0; m_act = '0; m_shd = '0; m_adp = '0; m_sdp = '0; m_pend = 1'b0;
        end else begin
            dg     = (q / DP) % ND;
            w      = q % DP;
            show   = (w >= BC);
            e_bcd  = m_act[4*dg +: 4];
            e_pend = m_pend;
            if (!cur_en) begin
                e_an = 4'hF; e_dpn = 1'b1; e_tick = 1'b0;
            end else begin
                lit    = show && !(cur_lz && dg != 0 && dg > msd(m_act) && !m_adp[dg]);
                e_an   = lit ? ~(4'b0001 << dg) : 4'hF;
                e_dpn  = !(show && m_adp[dg]);
                e_tick = (q > 0) && (q % FR == 0);
            end
            boundary = !cur_en || (q % FR == FR - 1);
            if (boundary && m_pend) begin
                m_act = m_shd; m_adp = m_sdp; m_pend = 1'b0;
            end
            if (ld) begin
                m_shd = d; m_sdp = dp; m_pend = 1'b1;
            end
            q = cur_en ? q + 1 : 0;
        end
        #1;
        check("bcd",        16'(bus.bcd),        16'(e_bcd));
        check("dig_an",     16'(bus.dig_an),     16'(e_an));
        check("dp_n",       16'(bus.dp_n),       16'(e_dpn));
        check("pending",    16'(bus.pending),    16'(e_pend));
        check("frame_tick", 16'(bus.frame_tick), 16'(e_tick));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    task automatic run_until(input int phase);
        for (int i = 0; i < FR; i++) begin
            if (q % FR == phase) break;
            tick(1'b0, 1'b0, 16'h0, 4'h0);
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic [3:0]  rdp;
        cur_en = 1'b1;
        cur_lz = 1'b0;

        // Reset held with en=1, then release and load mid-frame.
        tick(1'b1, 1'b0, 16'h0, 4'h0);
        tick(1'b1, 1'b0, 16'h0, 4'h0);
        tick(1'b1, 1'b0, 16'h0, 4'h0);
        idle(5);
        tick(1'b0, 1'b1, 16'h1234, 4'b0100);
        idle(2 * FR);

        // Double load within one frame, then a load on the commit edge.
        run_until(5);
        tick(1'b0, 1'b1, 16'h1111, 4'h0);
        idle(10);
        tick(1'b0, 1'b1, 16'h2222, 4'h0);
        run_until(FR - 1);
        tick(1'b0, 1'b1, 16'h3333, 4'h0);
        idle(2 * FR + 5);

        // Leading-zero suppression.
        cur_lz = 1'b1;
        tick(1'b0, 1'b1, 16'h0050, 4'h0);
        idle(2 * FR);
        tick(1'b0, 1'b1, 16'h0000, 4'h0);
        idle(2 * FR);
        tick(1'b0, 1'b1, 16'h0000, 4'b1000);
        idle(2 * FR);
        tick(1'b0, 1'b1, 16'h0A0F, 4'h0);
        idle(2 * FR);
        cur_lz = 1'b0;

        // Enable gating mid-SHOW of digit 2 with a pending load.
        run_until(24);
        tick(1'b0, 1'b1, 16'h4321, 4'b0010);
        cur_en = 1'b0;
        idle(4);
        cur_en = 1'b1;
        idle(FR + 5);

        // Reset during SHOW of digit 1 with pending set.
        run_until(10);
        tick(1'b0, 1'b1, 16'h9876, 4'b0001);
        run_until(15);
        tick(1'b1, 1'b0, 16'h0, 4'h0);
        idle(FR + 5);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < ND; i++)
                rd[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            rdp = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            if ($urandom_range(0, 199) == 0) cur_lz = !cur_lz;
            cur_en = ($urandom_range(0, 149) != 0);
            tick(($urandom_range(0, 399) == 0), ($urandom_range(0, 19) == 0), rd, rdp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Shares one BCD-to-7-segment decoder across NUM_DIG digits. Each step presents one digit's BCD code to the decoder and enables that digit's anode (active-low).
- Inserts a blanking gap between digits to prevent ghosting.
- Double-buffers the display value so an update only takes effect at a frame boundary, which avoids tearing.

Parameters:
- NUM_DIG, 4, number of digits scanned (legal range 2..8).
- CLK_DIV, 50000, clk cycles each digit is lit (minimum 2).
- BLANK_CYC, 500, clk cycles all anodes are off before each digit (minimum 1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  1 = scanning enabled; 0 = display dark.
- load  input  1  one-cycle strobe that captures data_in and dp_in into the shadow register.
- data_in  input  4*NUM_DIG  packed BCD nibbles; nibble 0 (bits 3:0) is the rightmost digit.
- dp_in  input  NUM_DIG  decimal point request per digit, active-high.
- lz_en  input  1  1 = suppress leading zeros.
- bcd  output  4  BCD code of the current digit, driven to the shared decoder.
- dig_an  output  NUM_DIG  digit anode enables, active-low; at most one bit is low at a time.
- dp_n  output  1  decimal point, active-low; forced to 1 while blanking.
- pending  output  1  shadow register holds a value not yet committed.
- frame_tick  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset values while rst=1: dig_an all 1s, bcd=0, dp_n=1, pending=0, frame_tick=0. Active and shadow registers cleared to 0. Digit index idx=0, state BLANK, cycle counter cnt=0.
- Reset takes precedence over every other input and aborts any scan in progress immediately.
- All outputs are registered and reflect the current state, idx and active register.
- Cycle 0 below is the first rising edge after rst falls.

State machine (two states):
- BLANK:
  - dig_an all 1s, dp_n=1.
  - bcd already shows nibble idx of the active register.
  - Lasts BLANK_CYC cycles, then moves to SHOW with cnt=0.
- SHOW:
  - dig_an bit idx low, unless that digit is suppressed.
  - dp_n = ~dp_active[idx].
  - Lasts CLK_DIV cycles.
  - On exit, idx increments and the state returns to BLANK.
- Timing: digit period = BLANK_CYC + CLK_DIV; frame = NUM_DIG × digit period.
- Wrap-around: leaving SHOW with idx = NUM_DIG-1 sets idx to 0. On that transition only:
  - frame_tick pulses for exactly one cycle.
  - If pending=1, shadow is copied into active and pending clears.

Load and pending:
- load=1 captures data_in and dp_in into shadow and sets pending=1.
- A second load while pending=1 overwrites shadow; pending stays 1 and only the last value is committed.
- load on the same cycle as a commit: the commit uses the shadow contents from before the load, the new data goes into shadow, and pending stays 1 for the next frame.

Leading-zero suppression (lz_en=1):
- Digit k is dark for the whole of its SHOW if all active nibbles k..NUM_DIG-1 are 0 and k ≠ 0.
- Digit 0 is always shown.
- A dark digit still takes its full slot, so timing is unchanged.
- dp_in[k]=1 overrides suppression for that digit and the digit is shown.

Invalid BCD:
- Nibble values 10..15 pass to bcd unchanged.
- Decoding them is the decoder's responsibility (it displays 0).

en=0:
- Synchronously forces state BLANK, idx=0, cnt=0, dig_an all 1s, dp_n=1.
- frame_tick stays 0.
- A pending shadow commits on the next clock, since the dark display cannot tear; load still operates.
- When en returns to 1, scanning restarts from BLANK at digit 0.

Test Plan:
Bench parameters: NUM_DIG=4, CLK_DIV=8, BLANK_CYC=2 (digit period 10, frame 40).
1. Reset check: hold rst=1 with en=1 -> dig_an=4'b1111, bcd=0, dp_n=1, pending=0. Release rst -> cycles 0-1 dig_an=1111; cycles 2-9 dig_an=1110, bcd=0.
2. Load mid-frame: load data_in=16'h1234, dp_in=4'b0100 at cycle 5 -> pending=1 from cycle 6. frame_tick pulses at cycle 40, and pending=0 from that edge. Next frame:
   - digit 0: bcd=4, dig_an=1110;
   - digit 2: bcd=2, dp_n=0;
   - digit 3: bcd=1, dig_an=0111.
3. Double load and load on boundary: load 16'h1111 then 16'h2222 within one frame -> only 2222 is displayed. A load of 16'h3333 on the commit cycle -> 2222 is shown for one frame, 3333 the frame after, and pending=1 between.
4. Leading-zero suppression: lz_en=1 with 16'h0050 -> digits 3 and 2 keep dig_an=1111 during their SHOW; digits 1 and 0 light. With 16'h0000 only digit 0 lights. With dp_in=4'b1000, digit 3 lights.
5. Enable gating: drop en in mid-SHOW of digit 2 -> next cycle dig_an=1111 and idx=0. A pending load commits one cycle later. Raising en restarts with a 2-cycle blank, then digit 0.
6. Reset mid-operation: assert rst during SHOW of digit 1 with pending=1 -> all outputs at reset values next cycle and pending=0. The display shows 0 after release.
